// File: rtl/ddr_defs_pkg.sv
// Shared definitions for the DDR game-link frame sender: sync byte,
// FSM state encoding, default word width and the frame-length helper.
package ddr_defs;

  // First byte of every frame header
  localparam logic [7:0] SYNC_BYTE  = 8'hA5;

  // Default link word width
  localparam int         WORD_W_DEF = 16;

  // Frame phases, in transmission order
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_CTRL  = 3'd2,
    ST_SCORE = 3'd3,
    ST_STAT  = 3'd4,
    ST_ARW   = 3'd5,
    ST_CSUM  = 3'd6
  } state_t;

  // Total words on the wire for one frame: HDR + CTRL + payload + CSUM
  function automatic int frame_len(input int score_words,
                                   input int status_words,
                                   input int arrow_words);
    return 3 + score_words + status_words + arrow_words;
  endfunction

endpackage

// File: rtl/ddr_csum_acc.sv
// Running modulo-2^WORD_W sum of the payload words of one frame.
module ddr_csum_acc #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] sum
);

  // Accumulate on enable; clear wins so a new frame always starts from zero
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/ddr_frame_sender.sv
// DDR game-link frame transmitter: snapshots control/score/status on a
// start request and streams HDR, CTRL, SCORE, STATUS, ARROW and CSUM words
// over a valid/ready interface, fetching arrow words from an external RAM.
module ddr_frame_sender
  import ddr_defs::*;
#(
  parameter int WORD_W       = WORD_W_DEF,
  parameter int SCORE_WORDS  = 1,
  parameter int STATUS_WORDS = 2,
  parameter int ARROW_WORDS  = 400,
  parameter int ADDR_W       = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             pause,
  input  logic                             next_song,
  input  logic [SCORE_WORDS*WORD_W-1:0]    score,
  input  logic [STATUS_WORDS*WORD_W-1:0]   status,
  output logic                             rd_en,
  output logic [ADDR_W-1:0]                rd_addr,
  input  logic [WORD_W-1:0]                rd_data,
  output logic [WORD_W-1:0]                out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             frame_done,
  output logic [7:0]                       seq
);

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t                            state;
  state_t                            state_nx;
  logic                              pend;       // one-deep queued start
  logic                              rd_pend;    // arrow read in flight
  logic [ADDR_W:0]                   arw_cnt;    // arrow reads issued
  logic [15:0]                       cnt;        // words accepted in SCORE/STAT
  logic                              snap_pause;
  logic                              snap_next;
  logic [SCORE_WORDS*WORD_W-1:0]     snap_score;
  logic [STATUS_WORDS*WORD_W-1:0]    snap_status;
  logic [WORD_W-1:0]                 acc_sum;

  // ---------------------------------------------------------------------
  // Decode signals
  // ---------------------------------------------------------------------
  logic              free;       // output register may take a word this edge
  logic              hs;         // current word accepted this edge
  logic              last_hs;    // last word of the current phase accepted
  logic              csum_done;  // frame completes this edge
  logic              snap_en;    // a frame starts this edge
  logic              ld_en;
  state_t            ld_st;
  logic [15:0]       ld_idx;
  logic [WORD_W-1:0] ld_word;
  logic              arw_ld;
  logic              out_load;
  logic [WORD_W-1:0] out_word;
  logic              acc_en;
  logic [WORD_W-1:0] hdr_word;
  logic [WORD_W-1:0] ctrl_word;

  assign free      = !out_valid || out_ready;
  assign hs        = out_valid && out_ready;
  assign busy      = (state != ST_IDLE);
  assign csum_done = (state == ST_CSUM) && last_hs;
  assign snap_en   = !abort && (((state == ST_IDLE) && start) ||
                                (csum_done && (pend || start)));

  // Arrow reads are issued only into a free register with nothing in flight,
  // which caps arrow throughput at one word every two cycles.
  assign rd_en   = (state == ST_ARW) && !rd_pend && free && !abort &&
                   (int'(arw_cnt) < ARROW_WORDS);
  assign rd_addr = arw_cnt[ADDR_W-1:0];

  // HDR carries the sequence number of the frame it opens; CTRL places pause
  // at the bottom bit of the upper byte and next_song at bit 0.
  assign hdr_word  = (WORD_W'(SYNC_BYTE) << (WORD_W - 8)) | WORD_W'(seq);
  assign ctrl_word = (WORD_W'(snap_pause) << (WORD_W - 8)) | WORD_W'(snap_next);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // Advance the frame phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  // A phase exits once its last word is accepted; abort always returns to IDLE
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    last_hs  = 1'b0;
    state_nx = state;
    case (state)
      ST_HDR, ST_CTRL, ST_CSUM: last_hs = hs;
      ST_SCORE: last_hs = hs && (int'(cnt) == SCORE_WORDS - 1);
      ST_STAT:  last_hs = hs && (int'(cnt) == STATUS_WORDS - 1);
      ST_ARW:   last_hs = hs && !rd_pend && (int'(arw_cnt) == ARROW_WORDS);
      default:  last_hs = 1'b0;
    endcase

    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start)   state_nx = ST_HDR;
        ST_HDR:   if (last_hs) state_nx = ST_CTRL;
        ST_CTRL:  if (last_hs) state_nx = (SCORE_WORDS > 0)  ? ST_SCORE :
                                          (STATUS_WORDS > 0) ? ST_STAT  : ST_ARW;
        ST_SCORE: if (last_hs) state_nx = (STATUS_WORDS > 0) ? ST_STAT  : ST_ARW;
        ST_STAT:  if (last_hs) state_nx = ST_ARW;
        ST_ARW:   if (last_hs) state_nx = ST_CSUM;
        ST_CSUM:  if (last_hs) state_nx = (pend || start) ? ST_HDR : ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------
  // Choose the word entering the output register: the next word of this
  // phase, the first word of the next phase when the last one leaves, or
  // returning arrow data. A new frame's HDR is loaded one cycle after entry.
  always_comb begin
    ld_en   = 1'b0;
    ld_st   = state;
    ld_idx  = cnt;
    ld_word = '0;
    if (!abort) begin
      if (last_hs) begin
        ld_st  = state_nx;
        ld_idx = '0;
        ld_en  = (state != ST_CSUM) && (state_nx != ST_ARW);
      end else if (hs) begin
        ld_idx = cnt + 16'd1;
        ld_en  = (state != ST_ARW);
      end else if (!out_valid) begin
        ld_en  = (state != ST_IDLE) && (state != ST_ARW);
      end
    end

    case (ld_st)
      ST_HDR:   ld_word = hdr_word;
      ST_CTRL:  ld_word = ctrl_word;
      ST_SCORE: ld_word = snap_score[ld_idx*WORD_W +: WORD_W];
      ST_STAT:  ld_word = snap_status[ld_idx*WORD_W +: WORD_W];
      ST_CSUM:  ld_word = acc_sum;
      default:  ld_word = '0;
    endcase

    arw_ld   = rd_pend && !abort;
    out_load = ld_en || arw_ld;
    out_word = arw_ld ? rd_data : ld_word;
    acc_en   = arw_ld || (ld_en && (ld_st inside {ST_CTRL, ST_SCORE, ST_STAT}));
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  // Output register: loads only when free, so data holds under back-pressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (abort) begin
      out_valid <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out_data  <= out_word;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

  // Per-phase word counter, restarted on every phase change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (abort || (state_nx != state)) begin
      cnt <= '0;
    end else if (hs && ((state == ST_SCORE) || (state == ST_STAT))) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Arrow read sequencing: address counter and one-cycle in-flight flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arw_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_en;
      if (abort || (state_nx != ST_ARW)) begin
        arw_cnt <= '0;
      end else if (rd_en) begin
        arw_cnt <= arw_cnt + 1'b1;
      end
    end
  end

  // One-deep start queue; abort drops it, frame completion consumes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (abort || csum_done) begin
      pend <= 1'b0;
    end else if (start && busy) begin
      pend <= 1'b1;
    end
  end

  // Freeze frame inputs at frame start so later changes cannot tear a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_pause  <= 1'b0;
      snap_next   <= 1'b0;
      snap_score  <= '0;
      snap_status <= '0;
    end else if (snap_en) begin
      snap_pause  <= pause;
      snap_next   <= next_song;
      snap_score  <= score;
      snap_status <= status;
    end
  end

  // Completion pulse and rolling sequence number; abort suppresses both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      seq        <= '0;
    end else begin
      frame_done <= csum_done && !abort;
      if (csum_done && !abort) begin
        seq <= seq + 8'd1;
      end
    end
  end

  // Payload checksum, restarted at every frame start and on abort
  ddr_csum_acc #(
    .WORD_W (WORD_W)
  ) u_csum (
    .clk (clk),
    .rst (rst),
    .clr (snap_en || abort),
    .en  (acc_en),
    .din (out_word),
    .sum (acc_sum)
  );

endmodule

// File: tb/tb_ddr_frame_sender.sv
// Directed bench for ddr_frame_sender with a 4-word arrow RAM.
`timescale 1ns/1ps
module tb_ddr_frame_sender;
  import ddr_defs::*;

  localparam int WORD_W       = 16;
  localparam int SCORE_WORDS  = 1;
  localparam int STATUS_WORDS = 2;
  localparam int ARROW_WORDS  = 4;
  localparam int ADDR_W       = 9;
  localparam int FLEN         = frame_len(SCORE_WORDS, STATUS_WORDS, ARROW_WORDS);

  logic                           clk;
  logic                           rst;
  logic                           start;
  logic                           abort;
  logic                           pause;
  logic                           next_song;
  logic [SCORE_WORDS*WORD_W-1:0]  score;
  logic [STATUS_WORDS*WORD_W-1:0] status;
  logic                           rd_en;
  logic [ADDR_W-1:0]              rd_addr;
  logic [WORD_W-1:0]              rd_data;
  logic [WORD_W-1:0]              out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           busy;
  logic                           frame_done;
  logic [7:0]                     seq;

  int n_run  = 0;
  int n_fail = 0;

  ddr_frame_sender #(
    .WORD_W       (WORD_W),
    .SCORE_WORDS  (SCORE_WORDS),
    .STATUS_WORDS (STATUS_WORDS),
    .ARROW_WORDS  (ARROW_WORDS),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pause      (pause),
    .next_song  (next_song),
    .score      (score),
    .status     (status),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .seq        (seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arrow RAM: one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) rd_data <= (rd_addr < 9'd4) ? (16'h0096 + {14'd0, rd_addr[1:0]}) : 16'hDEAD;
  end

  // Sink monitor, sampled on the falling edge away from the active edge
  logic [15:0] got[$];
  int          done_cnt  = 0;
  int          bad_reads = 0;
  int          hold_err  = 0;
  int          reads[4]  = '{default: 0};
  logic        hold_pend = 1'b0;
  logic [15:0] hold_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend && !(out_valid && (out_data === hold_data))) hold_err <= hold_err + 1;
      if (out_valid && out_ready) got.push_back(out_data);
      if (frame_done) done_cnt <= done_cnt + 1;
      if (rd_en) begin
        if (rd_addr < 9'd4) reads[rd_addr[1:0]] <= reads[rd_addr[1:0]] + 1;
        else bad_reads <= bad_reads + 1;
      end
      hold_pend <= out_valid && !out_ready && !abort;
      hold_data <= out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int i, input logic [7:0] s);
    case (i)
      0:       return {8'hA5, s};
      1:       return 16'h0100;
      2:       return 16'h1234;
      3:       return 16'h0001;
      4:       return 16'h0002;
      5:       return 16'h0096;
      6:       return 16'h0097;
      7:       return 16'h0098;
      8:       return 16'h0099;
      default: return 16'h1595;
    endcase
  endfunction

  task automatic check_frame(input string tag, input int base, input logic [7:0] s);
    check({tag, "_present"}, 32'(got.size() >= base + FLEN), 32'd1);
    if (got.size() >= base + FLEN) begin
      for (int i = 0; i < FLEN; i++)
        check($sformatf("%s_w%0d", tag, i), 32'(got[base + i]), 32'(exp_word(i, s)));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Step until done_cnt reaches target; optional random back-pressure
  task automatic run_wait(input int target, input int budget, input bit bp, input string tag);
    for (int n = 0; n < budget && done_cnt < target; n++) begin
      if (bp) out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    check({tag, "_timeout"}, 32'(done_cnt >= target), 32'd1);
  endtask

  int base;
  int d0;
  int hb;
  int rb[4];
  bit found;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    pause = 1'b1; next_song = 1'b0;
    score = 16'h1234; status = 32'h0002_0001;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rd_en",     32'(rd_en),     32'd0);
    check("rst_rd_addr",   32'(rd_addr),   32'd0);
    check("rst_seq",       32'(seq),       32'd0);
    check("rst_done",      32'(frame_done), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic frame with start-to-header latency
    base = got.size(); d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("basic_busy_c1",  32'(busy),      32'd1);
    check("basic_valid_c1", 32'(out_valid), 32'd0);
    tick();
    check("basic_valid_c2", 32'(out_valid), 32'd1);
    check("basic_hdr_c2",   32'(out_data),  32'hA500);
    run_wait(d0 + 1, 60, 1'b0, "basic");
    repeat (3) tick();
    check("basic_len", 32'(got.size() - base), 32'(FLEN));
    check_frame("basic", base, 8'd0);
    check("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("basic_seq",      32'(seq),  32'd1);
    check("basic_idle",     32'(busy), 32'd0);

    // Random back-pressure
    do_reset();
    base = got.size(); d0 = done_cnt; hb = hold_err;
    for (int i = 0; i < 4; i++) rb[i] = reads[i];
    out_ready = 1'($urandom_range(0, 1));
    pulse_start();
    run_wait(d0 + 1, 400, 1'b1, "bp");
    repeat (3) tick();
    check("bp_len", 32'(got.size() - base), 32'(FLEN));
    check_frame("bp", base, 8'd0);
    check("bp_stable", 32'(hold_err - hb), 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_reads_a%0d", i), 32'(reads[i] - rb[i]), 32'd1);
    check("bp_bad_reads", 32'(bad_reads), 32'd0);

    // Snapshot: score changes one cycle after start
    do_reset();
    base = got.size(); d0 = done_cnt;
    pulse_start();
    score = 16'hFFFF;
    run_wait(d0 + 1, 60, 1'b0, "snap");
    repeat (3) tick();
    score = 16'h1234;
    check_frame("snap", base, 8'd0);

    // Queued start: two extra starts during frame 0, the last one is dropped
    do_reset();
    base = got.size(); d0 = done_cnt;
    pulse_start();
    tick(); tick();
    pulse_start();
    tick();
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (frame_done) found = 1'b1;
      else tick();
    end
    check("q_fd_seen", 32'(found), 32'd1);
    tick();
    check("q_hdr1_valid", 32'(out_valid), 32'd1);
    check("q_hdr1_data",  32'(out_data),  32'hA501);
    run_wait(d0 + 2, 80, 1'b0, "q");
    repeat (30) tick();
    check("q_done_cnt", 32'(done_cnt - d0), 32'd2);
    check("q_len", 32'(got.size() - base), 32'(2 * FLEN));
    check_frame("q_f0", base, 8'd0);
    check_frame("q_f1", base + FLEN, 8'd1);
    check("q_seq",  32'(seq),  32'd2);
    check("q_idle", 32'(busy), 32'd0);

    // Abort while reading arrow word 2
    do_reset();
    d0 = done_cnt;
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (rd_en && rd_addr == 9'd2) found = 1'b1;
      else tick();
    end
    check("ab_reached_a2", 32'(found), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", 32'(out_valid), 32'd0);
    check("ab_busy",  32'(busy),      32'd0);
    repeat (20) tick();
    check("ab_no_done", 32'(done_cnt - d0), 32'd0);
    check("ab_seq",     32'(seq),   32'd0);
    check("ab_rd_en",   32'(rd_en), 32'd0);
    base = got.size();
    pulse_start();
    run_wait(d0 + 1, 60, 1'b0, "ab_next");
    repeat (3) tick();
    check_frame("ab_next", base, 8'd0);

    // Asynchronous reset mid-frame, between clock edges
    do_reset();
    d0 = done_cnt;
    pulse_start();
    run_wait(d0 + 1, 60, 1'b0, "ar_pre");
    tick();
    pulse_start();
    repeat (4) tick();
    check("ar_mid_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 32'(out_valid),  32'd0);
    check("ar_out_data",  32'(out_data),   32'd0);
    check("ar_busy",      32'(busy),       32'd0);
    check("ar_rd_en",     32'(rd_en),      32'd0);
    check("ar_rd_addr",   32'(rd_addr),    32'd0);
    check("ar_seq",       32'(seq),        32'd0);
    check("ar_done",      32'(frame_done), 32'd0);
    #3;
    rst = 1'b0;
    tick();
    base = got.size(); d0 = done_cnt;
    pulse_start();
    run_wait(d0 + 1, 60, 1'b0, "ar_next");
    repeat (3) tick();
    check_frame("ar_next", base, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_frame_sender.md
# ddr_frame_sender

Parametrised frame transmitter for the DDR game link. On a start request it snapshots the game control, score and status inputs and streams one framed packet onto a valid/ready word interface toward the serial TX path. A packet is header, control word, score words, status words, arrow words and checksum. Arrow words are fetched from the external arrow RAM through a read port instead of a wide flat bus. Supports back-pressure, a one-deep queued start, abort and a rolling sequence number.

## Interface
- `WORD_W`, 16, output word width; must be ≥16
- `SCORE_WORDS`, 1, score words per frame
- `STATUS_WORDS`, 2, status words per frame
- `ARROW_WORDS`, 400, arrow words per frame; must be ≥1
- `ADDR_W`, 9, arrow RAM address width; 2^ADDR_W ≥ ARROW_WORDS
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request one frame (level sampled per cycle)
- `abort`  in  1  cancel current frame and any queued start
- `pause`, `next_song`  in  1 each  game control flags
- `score`  in  SCORE_WORDS*WORD_W  score; word 0 = least-significant slice
- `status`  in  STATUS_WORDS*WORD_W  status; word 0 = least-significant slice
- `rd_en`  out  1  arrow RAM read strobe
- `rd_addr`  out  ADDR_W  arrow word index
- `rd_data`  in  WORD_W  arrow RAM data; valid exactly 1 cycle after `rd_en`
- `out_data`  out  WORD_W  frame word
- `out_valid`  out  1  `out_data` holds a word
- `out_ready`  in  1  sink accepts the word this cycle
- `busy`  out  1  frame in progress (state ≠ IDLE)
- `frame_done`  out  1  one-cycle pulse after checksum word is accepted
- `seq`  out  8  sequence number of the next/current frame

## Operation
- Frame order: HDR = {8'hA5, (WORD_W-16) zeros, seq}; CTRL = {7'b0, pause, (WORD_W-9) zeros, next_song} (16-bit: {7'b0,pause,7'b0,next_song}); SCORE[0..]; STATUS[0..]; ARROW[0..ARROW_WORDS-1]; CSUM.
- Frame length: 3 + SCORE_WORDS + STATUS_WORDS + ARROW_WORDS words.
- CSUM: sum of all CTRL, SCORE, STATUS and ARROW words, modulo 2^WORD_W. HDR is excluded.
- FSM states: IDLE, HDR, CTRL, SCORE, STAT, ARW, CSUM. Counters advance on the handshake (`out_valid && out_ready`). A state exits after its last word is accepted.
- Output register is free when `!out_valid || out_ready`. A word is loaded into it only when it is free.
- Snapshot: `pause`, `next_song`, `score` and `status` are registered on the edge that leaves IDLE or starts a queued frame. Later input changes do not affect that frame.
- ARW state:
  - `rd_en` is asserted (combinational) when no read is pending, the output register is free and `arw_cnt < ARROW_WORDS`.
  - `rd_addr = arw_cnt`.
  - `rd_data` is loaded into the output register on the next edge.
  - Maximum arrow throughput is one word per 2 cycles.
- `start` while busy sets a one-deep pending flag; further starts are ignored. After the CSUM handshake: `seq` += 1 (wraps 255→0), `frame_done` pulses, and the FSM goes to HDR with a fresh snapshot if pending, else to IDLE.
- `abort`, on the next edge: state → IDLE, `out_valid` → 0, pending cleared, read pending dropped. `seq` is unchanged and `frame_done` does not pulse. `abort` has priority over a simultaneous `start`.
- `rst`, asynchronously: `out_valid` 0, `out_data` 0, `rd_en` 0, `rd_addr` 0, `busy` 0, `frame_done` 0, `seq` 0, pending 0, state IDLE, all counters and checksum 0.

## Timing
- `start` high in cycle c (IDLE) → `busy` high in c+1 → HDR on `out_data` with `out_valid` in c+2.
- Non-arrow words: one per cycle while `out_ready` is held high.
- While `out_valid && !out_ready`, `out_data` must be held stable.
- `frame_done` is high in the cycle after the CSUM handshake edge.
- Queued frame: its HDR is valid 1 cycle after `frame_done`'s edge.

## Structure
- Shared `ddr_defs` package/include holds: SYNC_BYTE = 8'hA5, state encoding, `WORD_W` default, and a frame-length constant function.
- Sub-module `ddr_csum_acc`: WORD_W accumulator with clear/enable, cleared at frame start and on abort.
- Top level holds the FSM, snapshot registers, output register and read sequencing.

## Test plan
Bench parameters: WORD_W=16, SCORE_WORDS=1, STATUS_WORDS=2, ARROW_WORDS=4. RAM holds 0096, 0097, 0098, 0099.
- **Basic frame.** pause=1, next_song=0, score=1234, status={0002,0001}, `out_ready`=1, start → A500, 0100, 1234, 0001, 0002, 0096, 0097, 0098, 0099, 1595; `frame_done` once; `seq`=1.
- **Back-pressure.** Random `out_ready` → identical 10-word sequence; `out_data` stable whenever valid && !ready; `rd_addr` 0..3 each read exactly once.
- **Snapshot.** Change score to FFFF one cycle after start → frame still carries 1234; CSUM is still 1595.
- **Queued start.** Two extra starts during frame 0 → frame 1 (header A501) starts immediately after, and the third start is dropped. Exactly two `frame_done` pulses.
- **Abort.** Abort while `rd_addr`=2 → `out_valid` 0 and `busy` 0 next cycle; no `frame_done`; next frame header A500.
- **Async reset.** Assert `rst` mid-frame between clock edges → all outputs 0 immediately; after release, start yields header A500.
